// File: rtl/debounce_multi_if.sv
// Button-side signal bundle for debounce_multi: raw inputs in, debounced level and strobes out.
// The release strobe is called rel because release is a reserved word in SystemVerilog.
interface debounce_multi_if #(
   parameter int NUM_BTN = 5
);
   logic [NUM_BTN-1:0] button;
   logic [NUM_BTN-1:0] out;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] rel;
   logic [NUM_BTN-1:0] hold;
   logic [NUM_BTN-1:0] rpt;

   modport master (
      input  button,
      output out, press, rel, hold, rpt
   );

   modport slave (
      output button,
      input  out, press, rel, hold, rpt
   );
endinterface

// File: rtl/debounce_multi.sv
// N-channel button debouncer with input synchronisers, polarity mask, press/release strobes
// and long-press hold detection with optional auto-repeat.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | debounced level low, or high with no press seen since reset
// ST_WAIT    | pressed, timing towards the hold strobe
// ST_REPEAT  | hold issued, emitting a repeat strobe every REPEAT_CYCLES
// ST_HELD    | hold issued and auto-repeat disabled; silent until release
module debounce_multi #(
   parameter int                 NUM_BTN       = 5,
   parameter int                 DB_CYCLES     = 4000,
   parameter int                 HOLD_CYCLES   = 50000000,
   parameter int                 REPEAT_CYCLES = 10000000,
   parameter logic [NUM_BTN-1:0] ACTIVE_LOW    = '0
) (
   input logic              clock,
   input logic              reset,
   debounce_multi_if.master bus
);

   localparam int DW   = $clog2(DB_CYCLES + 1);
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);

   localparam logic [DW-1:0] DB_LOAD   = DW'(DB_CYCLES);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] RPT_LOAD  = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REPEAT,
      ST_HELD
   } state_t;

   logic [NUM_BTN-1:0] out_v;
   logic [NUM_BTN-1:0] press_v;
   logic [NUM_BTN-1:0] rel_v;
   logic [NUM_BTN-1:0] hold_v;
   logic [NUM_BTN-1:0] rpt_v;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic          s1;
      logic          s2;
      logic          cand;
      logic          lvl;
      logic [DW-1:0] dcnt;
      logic          settle;
      logic          rise;
      logic          fall;
      logic          press_q;
      logic          rel_q;

      state_t        state;
      state_t        state_nx;
      logic [HW-1:0] hcnt;
      logic [HW-1:0] hcnt_nx;
      logic          hold_q;
      logic          hold_nx;
      logic          rpt_q;
      logic          rpt_nx;

      // dcnt is a down-counter: reloaded on every candidate change, terminal at zero.
      assign settle = (dcnt == '0) && (cand != lvl);
      assign rise   = settle && cand;
      assign fall   = settle && !cand;

      always_ff @(posedge clock) begin
         if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cand    <= 1'b0;
            dcnt    <= '0;
            lvl     <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            s1 <= bus.button[i] ^ ACTIVE_LOW[i];
            s2 <= s1;
            if (s2 != cand) begin
               cand <= s2;
               dcnt <= DB_LOAD;
            end else if (dcnt != '0) begin
               dcnt <= dcnt - 1'b1;
            end
            if (settle) begin
               lvl <= cand;
            end
            press_q <= rise;
            rel_q   <= fall;
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            state  <= ST_IDLE;
            hcnt   <= '0;
            hold_q <= 1'b0;
            rpt_q  <= 1'b0;
         end else begin
            state  <= state_nx;
            hcnt   <= hcnt_nx;
            hold_q <= hold_nx;
            rpt_q  <= rpt_nx;
         end
      end

      // A debounced fall overrides everything, so hold/rpt can never share a cycle with rel.
      always_comb begin
         state_nx = state;
         hcnt_nx  = hcnt;
         hold_nx  = 1'b0;
         rpt_nx   = 1'b0;
         if (fall) begin
            state_nx = ST_IDLE;
            hcnt_nx  = '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     state_nx = ST_WAIT;
                     hcnt_nx  = HOLD_LOAD;
                  end
               end
               ST_WAIT: begin
                  if (hcnt == '0) begin
                     hold_nx = 1'b1;
                     if (REPEAT_CYCLES != 0) begin
                        state_nx = ST_REPEAT;
                        hcnt_nx  = RPT_LOAD;
                     end else begin
                        state_nx = ST_HELD;
                     end
                  end else begin
                     hcnt_nx = hcnt - 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (hcnt == '0) begin
                     rpt_nx  = 1'b1;
                     hcnt_nx = RPT_LOAD;
                  end else begin
                     hcnt_nx = hcnt - 1'b1;
                  end
               end
               ST_HELD: begin
                  state_nx = ST_HELD;
               end
               default: begin
                  state_nx = ST_IDLE;
                  hcnt_nx  = '0;
               end
            endcase
         end
      end

      assign out_v[i]   = lvl;
      assign press_v[i] = press_q;
      assign rel_v[i]   = rel_q;
      assign hold_v[i]  = hold_q;
      assign rpt_v[i]   = rpt_q;
   end

   assign bus.out   = out_v;
   assign bus.press = press_v;
   assign bus.rel   = rel_v;
   assign bus.hold  = hold_v;
   assign bus.rpt   = rpt_v;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: a sample-window reference model feeds a per-cycle
// scoreboard queue, plus directed latency checks for the named scenarios.
module tb_debounce_multi;
   localparam int             N    = 5;
   localparam int             DB   = 4;
   localparam int             HOLD = 20;
   localparam int             RPT  = 8;
   localparam logic [N-1:0]   AL   = 5'b01000;
   localparam int             L    = DB + 4;

   typedef struct packed {
      logic [N-1:0] out;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic [N-1:0] hold;
      logic [N-1:0] rpt;
   } resp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   debounce_multi_if #(.NUM_BTN(N)) bus_if ();

   debounce_multi #(
      .NUM_BTN      (N),
      .DB_CYCLES    (DB),
      .HOLD_CYCLES  (HOLD),
      .REPEAT_CYCLES(RPT),
      .ACTIVE_LOW   (AL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clock = ~clock;

   int    tests = 0;
   int    fails = 0;
   resp_t expq[$];

   // Reference model: the level follows a channel once its last DB+1 synchronised samples
   // (taken 3..DB+3 edges ago) agree; hold/rpt are derived from edges elapsed since press.
   bit hist  [N][L];
   bit out_m [N];
   int since [N];

   initial begin
      for (int i = 0; i < N; i++) begin
         since[i] = -1;
         out_m[i] = 1'b0;
      end
   end

   always @(posedge clock) begin
      resp_t e;
      bit    smp, ones, zeros, nv, pr, rl;
      e = '0;
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            for (int k = 0; k < L; k++) hist[i][k] = 1'b0;
            out_m[i] = 1'b0;
            since[i] = -1;
         end else begin
            smp = bus_if.button[i] ^ AL[i];
            for (int k = L - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = smp;
            ones  = 1'b1;
            zeros = 1'b1;
            for (int k = 3; k <= DB + 3; k++) begin
               if (!hist[i][k]) ones  = 1'b0;
               if (hist[i][k])  zeros = 1'b0;
            end
            nv = ones ? 1'b1 : (zeros ? 1'b0 : out_m[i]);
            pr = nv && !out_m[i];
            rl = !nv && out_m[i];
            if (pr)      since[i] = 0;
            else if (nv) since[i] = since[i] + 1;
            else         since[i] = -1;
            e.out[i]   = nv;
            e.press[i] = pr;
            e.rel[i]   = rl;
            e.hold[i]  = nv && (since[i] == HOLD);
            e.rpt[i]   = nv && (RPT != 0) && (since[i] > HOLD) && (((since[i] - HOLD) % RPT) == 0);
            out_m[i]   = nv;
         end
      end
      expq.push_back(e);
   end

   always @(negedge clock) begin
      resp_t e, a;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         a = '{out: bus_if.out, press: bus_if.press, rel: bus_if.rel,
               hold: bus_if.hold, rpt: bus_if.rpt};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL scoreboard t=%0t got out=%b press=%b rel=%b hold=%b rpt=%b expected out=%b press=%b rel=%b hold=%b rpt=%b",
                     $time, a.out, a.press, a.rel, a.hold, a.rpt, e.out, e.press, e.rel, e.hold, e.rpt);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   function automatic logic [N-1:0] strobe(input int kind);
      case (kind)
         0:       return bus_if.out;
         1:       return bus_if.press;
         2:       return bus_if.rel;
         3:       return bus_if.hold;
         default: return bus_if.rpt;
      endcase
   endfunction

   // Edges until the selected output of channel ch is seen high; -1 on timeout.
   task automatic wait_strobe(input int ch, input int kind, input int maxc, output int n);
      logic [N-1:0] v;
      n = -1;
      for (int k = 1; k <= maxc; k++) begin
         tick(1);
         v = strobe(kind);
         if (v[ch]) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           n;
      int           seen;
      int           dur [N];
      logic [N-1:0] btn;

      bus_if.button = AL;
      reset = 1'b1;
      tick(12);
      reset = 1'b0;
      check("reset_out", int'(bus_if.out), 0);
      tick(10);
      check("idle_out_ch3_active_low", int'(bus_if.out[3]), 0);

      // 1: single press latency and strobe width
      bus_if.button[0] = 1'b1;
      wait_strobe(0, 1, 20, n);
      check("s1_press_latency", n, 8);
      check("s1_other_press", int'(bus_if.press & 5'b11110), 0);
      check("s1_out0", int'(bus_if.out[0]), 1);
      tick(1);
      check("s1_press_one_cycle", int'(bus_if.press[0]), 0);
      bus_if.button[0] = 1'b0;
      wait_strobe(0, 2, 20, n);
      check("s1_release_latency", n, 8);
      tick(10);

      // 2: short pulses never debounce
      seen = 0;
      for (int r = 0; r < 6; r++) begin
         bus_if.button[1] = 1'b1;
         for (int k = 0; k < 3; k++) begin
            tick(1);
            seen = seen | int'(bus_if.out[1]) | int'(bus_if.press[1]);
         end
         bus_if.button[1] = 1'b0;
         for (int k = 0; k < 3; k++) begin
            tick(1);
            seen = seen | int'(bus_if.out[1]) | int'(bus_if.press[1]);
         end
      end
      check("s2_glitch_suppressed", seen, 0);
      tick(10);

      // 3: long press, hold then auto-repeat, release stops repeats
      bus_if.button[2] = 1'b1;
      wait_strobe(2, 1, 20, n);
      check("s3_press_latency", n, 8);
      wait_strobe(2, 3, 40, n);
      check("s3_hold_after_press", n, HOLD);
      wait_strobe(2, 4, 20, n);
      check("s3_first_rpt", n, RPT);
      wait_strobe(2, 4, 20, n);
      check("s3_second_rpt", n, RPT);
      tick(24);
      bus_if.button[2] = 1'b0;
      wait_strobe(2, 2, 20, n);
      check("s3_release_latency", n, 8);
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick(1);
         seen = seen | int'(bus_if.rpt[2]) | int'(bus_if.hold[2]);
      end
      check("s3_no_rpt_after_release", seen, 0);

      // 4: active-low channel
      bus_if.button[3] = 1'b0;
      wait_strobe(3, 1, 20, n);
      check("s4_active_low_press", n, 8);
      bus_if.button[3] = 1'b1;
      tick(12);

      // 5: simultaneous presses
      bus_if.button[0] = 1'b1;
      bus_if.button[4] = 1'b1;
      wait_strobe(0, 1, 20, n);
      check("s5_press0_latency", n, 8);
      check("s5_press4_same_cycle", int'(bus_if.press[4]), 1);
      bus_if.button[0] = 1'b0;
      bus_if.button[4] = 1'b0;
      tick(12);

      // 6: reset in the middle of a hold
      bus_if.button[2] = 1'b1;
      wait_strobe(2, 1, 20, n);
      check("s6_press_latency", n, 8);
      tick(10);
      reset = 1'b1;
      tick(1);
      check("s6_reset_clears", int'({bus_if.out, bus_if.press, bus_if.rel, bus_if.hold, bus_if.rpt}), 0);
      reset = 1'b0;
      wait_strobe(2, 1, 20, n);
      check("s6_repress_after_reset", n, 8);
      bus_if.button[2] = 1'b0;
      tick(15);

      // Random phase: per-channel random hold/gap durations, occasional short reset
      btn = AL;
      for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 12);
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            dur[i]--;
            if (dur[i] <= 0) begin
               btn[i] = ~btn[i];
               case ($urandom_range(0, 3))
                  0:       dur[i] = $urandom_range(1, 4);
                  1:       dur[i] = $urandom_range(5, 12);
                  2:       dur[i] = $urandom_range(13, 30);
                  default: dur[i] = $urandom_range(31, 60);
               endcase
            end
         end
         bus_if.button = btn;
         reset = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      reset = 1'b0;
      bus_if.button = AL;
      tick(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
